// File: rtl/mfm_encoder.sv
// MFM write-data encoder: serializes bytes from a single holding register into
// clock/data half-cells of HC clocks and emits a pulse on each 1 half-cell.
module mfm_encoder #(
   parameter int clkspd     = 65000000,
   parameter int bitrate    = 500000,
   parameter int pulsewidth = 8
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Enable,
   input  logic [7:0] i_Data,
   input  logic       i_Sync,
   input  logic       i_Valid,
   output logic       o_Ready,
   output logic       o_Write,
   output logic       o_Busy,
   output logic       o_Underrun
);

   localparam int HC = clkspd / (2 * bitrate);
   localparam int CW = $clog2(HC + 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   logic [7:0]    hold_data;
   logic          hold_sync;
   logic          hold_full;
   logic [7:0]    sh_data;
   logic          sh_sync;
   logic          prev_data;
   logic [2:0]    bit_idx;
   logic          phase;      // 0: clock half-cell, 1: data half-cell
   logic [CW-1:0] cnt;

   logic cur_bit;
   logic half_val;
   logic last_cnt;
   logic accept;

   assign o_Ready  = i_Enable && !hold_full;
   assign o_Busy   = (state == SEND);
   assign accept   = i_Valid && o_Ready;
   assign cur_bit  = sh_data[bit_idx];
   assign last_cnt = (cnt == CW'(HC - 1));
   // Sync marks drop the clock transition between bits 3 and 2.
   assign half_val = phase ? cur_bit
                           : (!prev_data && !cur_bit && !(sh_sync && bit_idx == 3'd2));

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state      <= IDLE;
         hold_data  <= '0;
         hold_sync  <= 1'b0;
         hold_full  <= 1'b0;
         sh_data    <= '0;
         sh_sync    <= 1'b0;
         prev_data  <= 1'b0;
         bit_idx    <= '0;
         phase      <= 1'b0;
         cnt        <= '0;
         o_Write    <= 1'b0;
         o_Underrun <= 1'b0;
      end else if (!i_Enable) begin
         state      <= IDLE;
         hold_full  <= 1'b0;
         prev_data  <= 1'b0;
         phase      <= 1'b0;
         cnt        <= '0;
         o_Write    <= 1'b0;
         o_Underrun <= 1'b0;
      end else begin
         if (accept) begin
            hold_data <= i_Data;
            hold_sync <= i_Sync;
            hold_full <= 1'b1;
         end
         case (state)
            IDLE: begin
               o_Write <= 1'b0;
               if (hold_full) begin
                  state     <= SEND;
                  sh_data   <= hold_data;
                  sh_sync   <= hold_sync;
                  hold_full <= 1'b0;
                  prev_data <= 1'b0;
                  bit_idx   <= 3'd7;
                  phase     <= 1'b0;
                  cnt       <= '0;
               end
            end
            SEND: begin
               o_Write <= half_val && (cnt < CW'(pulsewidth));
               if (!last_cnt) begin
                  cnt <= cnt + 1'b1;
               end else begin
                  cnt <= '0;
                  if (!phase) begin
                     phase <= 1'b1;
                  end else begin
                     phase     <= 1'b0;
                     prev_data <= cur_bit;
                     if (bit_idx != 3'd0) begin
                        bit_idx <= bit_idx - 1'b1;
                     end else if (hold_full) begin
                        // Seamless reload keeps the half-cell stream gap-free.
                        sh_data   <= hold_data;
                        sh_sync   <= hold_sync;
                        hold_full <= 1'b0;
                        bit_idx   <= 3'd7;
                     end else begin
                        state      <= IDLE;
                        o_Underrun <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mfm_encoder.sv
// Randomized self-checking bench for mfm_encoder against a half-cell reference
// model built directly from the MFM clock/data rules.
module tb_mfm_encoder;

   localparam int HC = 4;
   localparam int PW = 1;

   logic       i_Clk = 1'b0;
   logic       i_Reset;
   logic       i_Enable;
   logic [7:0] i_Data;
   logic       i_Sync;
   logic       i_Valid;
   logic       o_Ready;
   logic       o_Write;
   logic       o_Busy;
   logic       o_Underrun;

   mfm_encoder #(.clkspd(8), .bitrate(1), .pulsewidth(PW)) dut (
      .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Enable(i_Enable), .i_Data(i_Data),
      .i_Sync(i_Sync), .i_Valid(i_Valid), .o_Ready(o_Ready), .o_Write(o_Write),
      .o_Busy(o_Busy), .o_Underrun(o_Underrun)
   );

   always #5 i_Clk = ~i_Clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]  q_data[$];
   logic        q_sync[$];
   logic [15:0] exp_w[$];
   logic [15:0] got_w[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: each bit -> {clock, data}; clock = no 1 on either side, sync drops bit 2's clock.
   task automatic build_model();
      logic prev;
      logic d;
      logic c;
      logic [7:0]  b;
      logic [15:0] w;
      prev = 1'b0;
      exp_w.delete();
      foreach (q_data[n]) begin
         b = q_data[n];
         w = '0;
         for (int i = 7; i >= 0; i--) begin
            d = b[i];
            c = !prev && !d && !(q_sync[n] && i == 2);
            w = {w[13:0], c, d};
            prev = d;
         end
         exp_w.push_back(w);
      end
   endtask

   task automatic clear_enable(input string tag);
      i_Enable = 1'b0;
      @(posedge i_Clk);
      @(negedge i_Clk);
      chk({tag, " ready while disabled"}, o_Ready, 1'b0);
      chk({tag, " underrun cleared"}, o_Underrun, 1'b0);
      i_Enable = 1'b1;
   endtask

   // Feeds q_data as fast as o_Ready allows and checks every output cycle.
   task automatic run_stream(input string tag);
      int n;
      int idx;
      int k;
      int total;
      int j;
      int h;
      int p;
      bit done;
      bit drive;
      logic ew;
      logic [15:0] cw;
      logic [15:0] wv;
      n = q_data.size();
      idx = 0;
      k = -1;
      total = n * 16 * HC;
      done = 1'b0;
      cw = '0;
      build_model();
      got_w.delete();
      clear_enable(tag);
      for (int cyc = 0; cyc < total + 100 && !done; cyc++) begin
         drive = o_Ready && (idx < n);
         i_Valid = drive;
         i_Data  = drive ? q_data[idx] : 8'h00;
         i_Sync  = drive ? q_sync[idx] : 1'b0;
         @(posedge i_Clk);
         if (k >= 0) k++;
         if (drive) begin
            if (k < 0) k = 0;
            idx++;
         end
         @(negedge i_Clk);
         if (k >= 2) begin
            j = k - 2;
            h = j / HC;
            p = j % HC;
            wv = exp_w[h / 16];
            ew = (p < PW) ? wv[15 - (h % 16)] : 1'b0;
            chk({tag, " write/busy"}, {o_Write, o_Busy}, {ew, (j != total - 1)});
            if (p == 0) cw = {cw[14:0], o_Write};
            if (p == 0 && h % 16 == 15) got_w.push_back(cw);
            if (j == total - 2) chk({tag, " underrun before end"}, o_Underrun, 1'b0);
            if (j == total - 1) done = 1'b1;
         end
      end
      i_Valid = 1'b0;
      if (!done) chk({tag, " timeout"}, 1'b0, 1'b1);
      chk({tag, " word count"}, got_w.size(), n);
      if (got_w.size() == n)
         foreach (got_w[i]) chk({tag, " word"}, got_w[i], exp_w[i]);
      chk({tag, " underrun at end"}, o_Underrun, 1'b1);
   endtask

   task automatic count_pulses(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge i_Clk);
         if (o_Write) pulses++;
      end
   endtask

   task automatic accept_one(input logic [7:0] d);
      i_Valid = 1'b1;
      i_Data  = d;
      i_Sync  = 1'b0;
      @(posedge i_Clk);
      @(negedge i_Clk);
      i_Valid = 1'b0;
   endtask

   initial begin
      int pulses;
      int waited;
      int nb;
      i_Reset = 1'b1; i_Enable = 1'b0; i_Data = '0; i_Sync = 1'b0; i_Valid = 1'b0;
      repeat (2) @(negedge i_Clk);
      chk("reset write", o_Write, 1'b0);
      chk("reset busy", o_Busy, 1'b0);
      chk("reset underrun", o_Underrun, 1'b0);
      chk("reset ready", o_Ready, 1'b0);
      i_Reset = 1'b0;
      i_Enable = 1'b1;
      #1 chk("ready after enable", o_Ready, 1'b1);
      @(negedge i_Clk);

      q_data = '{8'h00}; q_sync = '{1'b0};
      run_stream("x00");
      if (got_w.size() == 1) chk("x00 pattern", got_w[0], 16'hAAAA);
      chk("x00 busy end", o_Busy, 1'b0);

      q_data = '{8'hA1}; q_sync = '{1'b1};
      run_stream("A1 sync");
      if (got_w.size() == 1) chk("A1 sync pattern", got_w[0], 16'h4489);

      q_data = '{8'hA1}; q_sync = '{1'b0};
      run_stream("A1 data");
      if (got_w.size() == 1) chk("A1 data pattern", got_w[0], 16'h44A9);

      q_data = '{8'hFF, 8'h00}; q_sync = '{1'b0, 1'b0};
      run_stream("FF 00");
      if (got_w.size() == 2) begin
         chk("FF pattern", got_w[0], 16'h5555);
         chk("00 after FF pattern", got_w[1], 16'h2AAA);
      end

      q_data = '{8'h80}; q_sync = '{1'b0};
      run_stream("x80");
      if (got_w.size() == 1) chk("x80 pattern", got_w[0], 16'h4AAA);

      for (int r = 0; r < 6; r++) begin
         q_data.delete(); q_sync.delete();
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            q_data.push_back(8'($urandom));
            q_sync.push_back(1'($urandom));
         end
         run_stream($sformatf("rand%0d", r));
      end

      // Enable drop during bit 4 of 0x00 (its clock half-cell pulses at k=26).
      clear_enable("drop");
      accept_one(8'h00);
      repeat (26) @(posedge i_Clk);
      @(negedge i_Clk);
      chk("drop pre write", o_Write, 1'b1);
      i_Enable = 1'b0;
      @(posedge i_Clk);
      @(negedge i_Clk);
      chk("drop write", o_Write, 1'b0);
      chk("drop busy", o_Busy, 1'b0);
      chk("drop ready", o_Ready, 1'b0);
      count_pulses(40, pulses);
      chk("drop ready held", o_Ready, 1'b0);
      i_Enable = 1'b1;
      count_pulses(40, nb);
      chk("drop no pulses", pulses + nb, 0);
      chk("drop idle busy", o_Busy, 1'b0);

      // Asynchronous reset while a pulse is on the line.
      clear_enable("rst");
      accept_one(8'h00);
      waited = 0;
      while (!o_Write && waited < 40) begin
         @(negedge i_Clk);
         waited++;
      end
      chk("rst pulse seen", o_Write, 1'b1);
      #2 i_Reset = 1'b1;
      #1;
      chk("rst write", o_Write, 1'b0);
      chk("rst busy", o_Busy, 1'b0);
      chk("rst underrun", o_Underrun, 1'b0);
      @(negedge i_Clk);
      i_Reset = 1'b0;
      count_pulses(40, pulses);
      chk("rst no pulses", pulses, 0);
      q_data = '{8'hFF}; q_sync = '{1'b0};
      run_stream("rst FF");
      if (got_w.size() == 1) chk("rst FF pattern", got_w[0], 16'h5555);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
